// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode seven-segment driver with per-digit blanking gap,
// double-buffered frame-aligned updates and optional leading-zero blanking.
module sevenseg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzb_en,
  input  logic                    blank_all,
  output logic [7:0]              segments,
  output logic [NUM_DIGITS-1:0]   digit_n,
  output logic                    frame_start
);

  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_index;
  logic [4*NUM_DIGITS-1:0] r_shadow_data, r_active_data;
  logic [NUM_DIGITS-1:0]   r_shadow_dp, r_active_dp;
  logic                    r_pending;
  logic [7:0]              r_segments;
  logic [NUM_DIGITS-1:0]   r_digit_n;
  logic                    r_frame_start;

  logic                    w_presc_wrap;
  logic                    w_frame_wrap;
  logic                    w_in_gap;
  logic [3:0]              w_nibble;
  logic                    w_dp;
  logic [7:0]              w_seg_lit;
  logic [NUM_DIGITS-1:0]   w_lzb_mask;
  logic [NUM_DIGITS-1:0]   w_digit_sel;

  // Active-low {dp,g,f,e,d,c,b,a}, dp unlit.
  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    case (nib)
      4'h0: seg_code = 8'hC0;
      4'h1: seg_code = 8'hF9;
      4'h2: seg_code = 8'hA4;
      4'h3: seg_code = 8'hB0;
      4'h4: seg_code = 8'h99;
      4'h5: seg_code = 8'h92;
      4'h6: seg_code = 8'h82;
      4'h7: seg_code = 8'hF8;
      4'h8: seg_code = 8'h80;
      4'h9: seg_code = 8'h90;
      4'hA: seg_code = 8'h88;
      4'hB: seg_code = 8'h83;
      4'hC: seg_code = 8'hC6;
      4'hD: seg_code = 8'hA1;
      4'hE: seg_code = 8'h86;
      default: seg_code = 8'h8E;
    endcase
  endfunction

  assign w_presc_wrap = (r_presc == PRESC_LAST);
  assign w_frame_wrap = w_presc_wrap && (r_index == INDEX_LAST);
  assign w_in_gap     = (r_presc < BLANK_END);
  assign w_nibble     = r_active_data[4*r_index +: 4];
  assign w_dp         = r_active_dp[r_index];
  assign w_seg_lit    = seg_code(w_nibble) & {~w_dp, 7'h7F};

  // A digit is a leading zero while every digit above it (and itself) is a zero with dp off.
  always_comb begin
    logic run;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_lzb_mask = '0;
    run        = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run           = run & (r_active_data[4*k +: 4] == 4'h0) & ~r_active_dp[k];
      w_lzb_mask[k] = run;
    end
  end

  always_comb begin
    w_digit_sel = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_digit_sel[k] = (r_index == IW'(k));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc       <= '0;
      r_index       <= '0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_active_data <= '0;
      r_active_dp   <= '0;
      r_pending     <= 1'b0;
      r_segments    <= 8'hFF;
      r_digit_n     <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_presc <= w_presc_wrap ? '0 : r_presc + 1'b1;
      if (w_presc_wrap) begin
        r_index <= w_frame_wrap ? '0 : r_index + 1'b1;
      end
      r_frame_start <= w_frame_wrap;

      if (w_frame_wrap && r_pending) begin
        r_active_data <= r_shadow_data;
        r_active_dp   <= r_shadow_dp;
        r_pending     <= 1'b0;
      end
      // Placed after the commit so a same-edge load keeps pending set for the next frame.
      if (load) begin
        r_shadow_data <= data_in;
        r_shadow_dp   <= dp_in;
        r_pending     <= 1'b1;
      end

      if (blank_all || w_in_gap) begin
        r_segments <= 8'hFF;
        r_digit_n  <= '1;
      end else begin
        r_segments <= (lzb_en && w_lzb_mask[r_index]) ? 8'hFF : w_seg_lit;
        r_digit_n  <= ~w_digit_sel;
      end
    end
  end

  assign segments    = r_segments;
  assign digit_n     = r_digit_n;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with NUM_DIGITS=4, DIV=4, BLANK_CYCLES=1 (16-cycle frames).
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        lzb_en = 1'b0;
  logic        blank_all = 1'b0;
  logic [7:0]  segments;
  logic [3:0]  digit_n;
  logic        frame_start;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] cap_seg [1:16];
  logic [3:0] cap_dn  [1:16];
  logic       cap_fs  [1:16];

  sevenseg_scan #(.NUM_DIGITS(4), .DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .lzb_en(lzb_en), .blank_all(blank_all), .segments(segments),
    .digit_n(digit_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Offset i (1..16) counts negedges after a frame_start sample; slot = (i-1)/4, first cycle blank.
  function automatic logic [3:0] exp_dn(input int i);
    logic [3:0] one;
    one = 4'b0001;
    if ((i - 1) % 4 == 0) return 4'b1111;
    return ~(one << ((i - 1) / 4));
  endfunction

  function automatic logic [7:0] exp_seg(input int i, input logic [31:0] e);
    if ((i - 1) % 4 == 0) return 8'hFF;
    return e[8*((i - 1) / 4) +: 8];
  endfunction

  task automatic capture();
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      cap_seg[i] = segments;
      cap_dn[i]  = digit_n;
      cap_fs[i]  = frame_start;
    end
  endtask

  task automatic wait_frame(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) found = 1'b1;
    end
    if (!found) begin
      n_total++;
      $display("FAIL %s: frame_start timeout, no pulse within 40 cycles", name);
    end
  endtask

  task automatic load_pulse(input logic [15:0] d, input logic [3:0] dp);
    load = 1'b1; data_in = d; dp_in = dp;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if (segments !== 8'hFF || digit_n !== 4'hF || frame_start !== 1'b0)
      $display("FAIL reset_state: seg=%h dn=%b fs=%b required seg=ff dn=1111 fs=0", segments, digit_n, frame_start);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    capture();
    for (int i = 1; i <= 16; i++) begin
      n_total++;
      if (cap_seg[i] !== exp_seg(i, 32'hC0C0C0C0) || cap_dn[i] !== exp_dn(i) || cap_fs[i] !== (i == 16))
        $display("FAIL scan off=%0d: seg=%h dn=%b fs=%b required seg=%h dn=%b fs=%b", i, cap_seg[i], cap_dn[i], cap_fs[i], exp_seg(i, 32'hC0C0C0C0), exp_dn(i), (i == 16));
      else n_pass++;
    end
  endtask

  task automatic test_load_commit();
    repeat (3) @(negedge clk);
    load_pulse(16'h12AF, 4'b0100);
    for (int i = 5; i <= 16; i++) begin
      @(negedge clk);
      n_total++;
      if (segments !== exp_seg(i, 32'hC0C0C0C0) || digit_n !== exp_dn(i) || frame_start !== (i == 16))
        $display("FAIL old_persist off=%0d: seg=%h dn=%b fs=%b required seg=%h dn=%b fs=%b", i, segments, digit_n, frame_start, exp_seg(i, 32'hC0C0C0C0), exp_dn(i), (i == 16));
      else n_pass++;
    end
    capture();
    for (int i = 1; i <= 16; i++) begin
      n_total++;
      if (cap_seg[i] !== exp_seg(i, 32'hF924888E) || cap_dn[i] !== exp_dn(i) || cap_fs[i] !== (i == 16))
        $display("FAIL commit off=%0d: seg=%h dn=%b fs=%b required seg=%h dn=%b fs=%b", i, cap_seg[i], cap_dn[i], cap_fs[i], exp_seg(i, 32'hF924888E), exp_dn(i), (i == 16));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    load_pulse(16'h0002, 4'b0000);
    repeat (14) @(negedge clk);
    load = 1'b1; data_in = 16'h0001; dp_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    n_total++;
    if (frame_start !== 1'b1)
      $display("FAIL same_edge_fs: fs=%b required 1", frame_start);
    else n_pass++;
    capture();
    for (int i = 1; i <= 16; i++) begin
      n_total++;
      if (cap_seg[i] !== exp_seg(i, 32'hC0C0C0A4) || cap_dn[i] !== exp_dn(i) || cap_fs[i] !== (i == 16))
        $display("FAIL same_edge_first off=%0d: seg=%h dn=%b required seg=%h dn=%b", i, cap_seg[i], cap_dn[i], exp_seg(i, 32'hC0C0C0A4), exp_dn(i));
      else n_pass++;
    end
    capture();
    for (int i = 1; i <= 16; i++) begin
      n_total++;
      if (cap_seg[i] !== exp_seg(i, 32'hC0C0C0F9) || cap_dn[i] !== exp_dn(i) || cap_fs[i] !== (i == 16))
        $display("FAIL same_edge_second off=%0d: seg=%h dn=%b required seg=%h dn=%b", i, cap_seg[i], cap_dn[i], exp_seg(i, 32'hC0C0C0F9), exp_dn(i));
      else n_pass++;
    end
  endtask

  task automatic test_lzb();
    lzb_en = 1'b1;
    load_pulse(16'h0050, 4'b0000);
    wait_frame("lzb_commit");
    capture();
    for (int i = 1; i <= 16; i++) begin
      n_total++;
      if (cap_seg[i] !== exp_seg(i, 32'hFFFF92C0) || cap_dn[i] !== exp_dn(i))
        $display("FAIL lzb off=%0d: seg=%h dn=%b required seg=%h dn=%b", i, cap_seg[i], cap_dn[i], exp_seg(i, 32'hFFFF92C0), exp_dn(i));
      else n_pass++;
    end
    load_pulse(16'h0050, 4'b0100);
    wait_frame("lzb_dp_commit");
    capture();
    for (int i = 1; i <= 16; i++) begin
      n_total++;
      if (cap_seg[i] !== exp_seg(i, 32'hFF4092C0) || cap_dn[i] !== exp_dn(i))
        $display("FAIL lzb_dp off=%0d: seg=%h dn=%b required seg=%h dn=%b", i, cap_seg[i], cap_dn[i], exp_seg(i, 32'hFF4092C0), exp_dn(i));
      else n_pass++;
    end
  endtask

  task automatic test_blank_all();
    lzb_en = 1'b0;
    @(negedge clk);
    blank_all = 1'b1;
    for (int i = 2; i <= 11; i++) begin
      @(negedge clk);
      n_total++;
      if (segments !== 8'hFF || digit_n !== 4'hF || frame_start !== 1'b0)
        $display("FAIL blank_all off=%0d: seg=%h dn=%b fs=%b required seg=ff dn=1111 fs=0", i, segments, digit_n, frame_start);
      else n_pass++;
    end
    blank_all = 1'b0;
    for (int i = 12; i <= 16; i++) begin
      @(negedge clk);
      n_total++;
      if (frame_start !== (i == 16) || digit_n !== exp_dn(i))
        $display("FAIL blank_release off=%0d: fs=%b dn=%b required fs=%b dn=%b", i, frame_start, digit_n, (i == 16), exp_dn(i));
      else n_pass++;
    end
    n_total++;
    if (segments !== 8'hC0)
      $display("FAIL blank_release_seg: seg=%h required c0", segments);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    load = 1'b1; data_in = 16'h1234; dp_in = 4'b1111;
    @(negedge clk);
    load = 1'b0;
    n_total++;
    if (digit_n !== 4'b1110)
      $display("FAIL pre_reset_lit: dn=%b required 1110", digit_n);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (segments !== 8'hFF || digit_n !== 4'hF || frame_start !== 1'b0)
      $display("FAIL async_reset: seg=%h dn=%b fs=%b required seg=ff dn=1111 fs=0", segments, digit_n, frame_start);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (digit_n !== 4'hF)
      $display("FAIL restart_gap: dn=%b required 1111", digit_n);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (digit_n !== 4'b1110 || segments !== 8'hC0)
      $display("FAIL restart_digit0: seg=%h dn=%b required seg=c0 dn=1110", segments, digit_n);
    else n_pass++;
    wait_frame("post_reset");
    capture();
    for (int i = 1; i <= 16; i++) begin
      n_total++;
      if (cap_seg[i] !== exp_seg(i, 32'hC0C0C0C0) || cap_dn[i] !== exp_dn(i))
        $display("FAIL pending_lost off=%0d: seg=%h dn=%b required seg=%h dn=%b", i, cap_seg[i], cap_dn[i], exp_seg(i, 32'hC0C0C0C0), exp_dn(i));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_back_to_back();
    test_lzb();
    test_blank_all();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Parametrised, time-multiplexed driver for a common-anode multi-digit seven-segment display.
- Accepts a packed vector of hex nibbles, per-digit decimal points and mode controls.
- Scans the digits one at a time, inserting a ghost-suppression blanking gap between digits.
- Sits between core logic and the board's display pins. New values are double-buffered and committed only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- DIV, 50000, clock cycles per digit slot (>= 2).
- BLANK_CYCLES, 500, cycles at the start of each slot with all digits off (0 .. DIV-1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; captures data_in/dp_in into the shadow buffer.
- data_in  in  4*NUM_DIGITS  hex nibbles; digit k = bits [4k+3:4k]; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal-point request per digit, 1 = lit.
- lzb_en  in  1  leading-zero blanking enable.
- blank_all  in  1  forces the display dark; scanning continues.
- segments  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- digit_n  out  NUM_DIGITS  active-low digit enables, one-hot-low or all 1.
- frame_start  out  1  one-cycle pulse when the digit index wraps to 0.

Behaviour:
- Reset (asynchronous, rst_n low): prescaler=0, index=0, shadow=0, active=0, pending=0, segments=8'hFF, digit_n=all 1, frame_start=0.
- Segment code for nibble, bit7 = 1 (dp unlit): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E. A lit dp clears bit7.
- Prescaler counts 0..DIV-1 and wraps. On wrap, index advances 0..NUM_DIGITS-1 and wraps to 0.
- Blanking gap: while prescaler < BLANK_CYCLES, the registered outputs are segments=FF and digit_n=all 1.
- Otherwise: digit_n[index]=0 and segments = code(active nibble[index]), dp applied.
- Output latency: outputs are registered, one cycle after the prescaler/index state they decode. Each digit is on for exactly DIV-BLANK_CYCLES consecutive cycles per slot.
- Loading: on load, shadow <= {data_in, dp_in} and pending <= 1. A later load before commit overwrites the shadow.
- Commit: when index wraps NUM_DIGITS-1 -> 0 and pending=1, active <= shadow and pending <= 0. frame_start pulses on this wrap whether or not a commit occurs.
- Load and commit on the same edge: commit uses the pre-edge shadow. The new load is held, and pending stays 1 for the next frame.
- Leading-zero blanking (lzb_en=1): scanning from digit NUM_DIGITS-1 downward, a digit is blanked (segments=FF, its digit_n still driven) while its nibble is 0 and its dp is 0.
  - The first non-zero nibble or lit dp stops the blanking.
  - Digit 0 is never blanked.
  - Evaluated on active data only.
- blank_all=1: segments=FF and digit_n=all 1 from the next cycle. The prescaler, index, commit and frame_start continue unaffected.
- Reset mid-frame: all state is cleared immediately. A pending shadow is discarded, and scanning restarts at digit 0, prescaler 0.

Test Plan:
- Reset/scan (NUM_DIGITS=4, DIV=4, BLANK_CYCLES=1): release reset, no load.
  - digit_n sequence per slot: 1 cycle 1111, then 3 cycles of 1110, 1101, 1011, 0111 in turn; segments=C0 when lit.
  - frame_start pulses every 16 cycles.
- Load/commit: load data_in=16'h12AF, dp_in=4'b0100 mid-frame.
  - Old digits persist until the next frame_start.
  - Next frame shows 8E, 88, 24 (digit 2 with dp), F9 on digits 0..3.
- Same-edge load and commit: load 16'h0001 on a commit edge while an earlier 16'h0002 is pending.
  - This frame shows 0002.
  - The following frame shows 0001.
- Leading-zero blanking: active=16'h0050, lzb_en=1 -> digits 3,2 segments=FF, digit 1=92, digit 0=C0. Then set dp_in[2]=1 -> digit 2 shows 40, digit 3 stays blank.
- blank_all: assert for 10 cycles -> segments=FF, digit_n=1111 throughout; frame_start timing unchanged.
- Async reset mid-frame: pull rst_n low with a load pending -> outputs go FF/1111 without a clock edge. After release, the display shows 0000 and the pending data is lost.
